// File: rtl/sipo_deser_pkg.sv
// Shared constants and helpers for the SIPO deserializer.
package sipo_pkg;
  localparam int WIDTH_DEF   = 4;
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

  // Bit-counter width for a given word size.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle of the deserializer.
interface sipo_deser_if #(parameter int WIDTH = sipo_pkg::WIDTH_DEF);
  logic             sin;
  logic             sin_en;
  logic             sin_start;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             overrun;
  logic             frame_err;
  logic             err_clr;

  modport master (
    output sin, sin_en, sin_start, pout_ready, err_clr,
    input  pout, pout_valid, overrun, frame_err
  );

  modport slave (
    input  sin, sin_en, sin_start, pout_ready, err_clr,
    output pout, pout_valid, overrun, frame_err
  );
endinterface

// File: rtl/sipo_deser_hold_reg.sv
// Output holding register: one word of slack, valid/ready handshake, overrun flag.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             pout_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             overrun
);
  logic accept;
  logic drop;

  // A new word can land when the register is empty or being drained this edge.
  assign accept = word_done && (!pout_valid || pout_ready);
  assign drop   = word_done && pout_valid && !pout_ready;

  // Holding register and valid flag; pout keeps its last value after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
    end else if (accept) begin
      pout       <= word;
      pout_valid <= 1'b1;
    end else if (pout_valid && pout_ready) begin
      pout_valid <= 1'b0;
    end
  end

  // Sticky overrun; a set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)           overrun <= 1'b0;
    else if (drop)     overrun <= 1'b1;
    else if (err_clr)  overrun <= 1'b0;
  end
endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: shift register, bit counter, framing check.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic         clk,
  input  logic         rst,
  sipo_deser_if.slave  sif
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             start;
  logic             word_done;
  logic             short_frame;

  // Bit order is fixed at elaboration time.
  generate
    if (MSB_FIRST == MSB_FIRST_C) begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], sif.sin};
    end else begin : g_lsb
      assign shifted = {sif.sin, sreg[WIDTH-1:1]};
    end
  endgenerate

  assign start       = sif.sin_en && sif.sin_start;
  assign short_frame = start && (cnt != '0);
  // A start bit is always bit 0, so it can never complete a word (WIDTH >= 2).
  assign word_done   = sif.sin_en && !sif.sin_start && (cnt == CNT_LAST);

  // Next bit count: start bit counts as bit 0, completion wraps to zero.
  always_comb begin
    cnt_nxt = cnt;
    if (start)          cnt_nxt = CW'(1);
    else if (word_done) cnt_nxt = '0;
    else if (sif.sin_en) cnt_nxt = cnt + CW'(1);
  end

  // Shift register and bit counter; stale bits from an aborted word shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (sif.sin_en) begin
      sreg <= shifted;
      cnt  <= cnt_nxt;
    end
  end

  // Sticky framing error; a set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)              sif.frame_err <= 1'b0;
    else if (short_frame) sif.frame_err <= 1'b1;
    else if (sif.err_clr) sif.frame_err <= 1'b0;
  end

  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .word       (shifted),
    .word_done  (word_done),
    .pout_ready (sif.pout_ready),
    .err_clr    (sif.err_clr),
    .pout       (sif.pout),
    .pout_valid (sif.pout_valid),
    .overrun    (sif.overrun)
  );
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: MSB-first and LSB-first instances fed the same bit stream.
module tb_sipo_deser;
  import sipo_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  sipo_deser_if #(.WIDTH(4)) ifm ();
  sipo_deser_if #(.WIDTH(4)) ifl ();

  assign ifl.sin        = ifm.sin;
  assign ifl.sin_en     = ifm.sin_en;
  assign ifl.sin_start  = ifm.sin_start;
  assign ifl.pout_ready = ifm.pout_ready;
  assign ifl.err_clr    = ifm.err_clr;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(MSB_FIRST_C)) u_msb (.clk(clk), .rst(rst), .sif(ifm));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(LSB_FIRST_C)) u_lsb (.clk(clk), .rst(rst), .sif(ifl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic st);
    ifm.sin       = b;
    ifm.sin_start = st;
    ifm.sin_en    = 1'b1;
    step();
    ifm.sin_en    = 1'b0;
    ifm.sin_start = 1'b0;
  endtask

  task automatic word_in(input logic [3:0] w, input logic st);
    for (int i = 3; i >= 0; i--) bit_in(w[i], st && (i == 3));
  endtask

  task automatic consume();
    ifm.pout_ready = 1'b1;
    step();
    ifm.pout_ready = 1'b0;
  endtask

  task automatic clr_err();
    ifm.err_clr = 1'b1;
    step();
    ifm.err_clr = 1'b0;
  endtask

  initial begin
    ifm.sin = 0; ifm.sin_en = 0; ifm.sin_start = 0;
    ifm.pout_ready = 0; ifm.err_clr = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset state and idle
    chk("rst_pout", 32'(ifm.pout), 0);
    chk("rst_valid", 32'(ifm.pout_valid), 0);
    chk("rst_ovr", 32'(ifm.overrun), 0);
    chk("rst_ferr", 32'(ifm.frame_err), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", 32'(ifm.pout_valid | ifl.pout_valid), 0);
      chk("idle_flags", 32'({ifm.overrun, ifm.frame_err}), 0);
    end

    // basic receive 1,1,0,0
    bit_in(1, 1); bit_in(1, 0); bit_in(0, 0);
    chk("basic_valid3", 32'(ifm.pout_valid), 0);
    bit_in(0, 0);
    chk("basic_valid", 32'(ifm.pout_valid), 1);
    chk("basic_msb", 32'(ifm.pout), 32'hC);
    chk("basic_lsb", 32'(ifl.pout), 32'h3);
    consume();
    chk("drain_valid", 32'(ifm.pout_valid), 0);
    chk("drain_hold", 32'(ifm.pout), 32'hC);

    // back-to-back with handshake on the completion edge
    word_in(4'b1100, 1);
    chk("b2b_first", 32'(ifm.pout), 32'hC);
    bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);
    ifm.pout_ready = 1'b1;
    bit_in(0, 0);
    ifm.pout_ready = 1'b0;
    chk("b2b_msb", 32'(ifm.pout), 32'h6);
    chk("b2b_lsb", 32'(ifl.pout), 32'h6);
    chk("b2b_valid", 32'(ifm.pout_valid), 1);
    chk("b2b_ovr", 32'(ifm.overrun), 0);
    consume();

    // overrun
    word_in(4'b1100, 1);
    chk("ovr_w1", 32'(ifm.overrun), 0);
    word_in(4'b0110, 0);
    chk("ovr_w2", 32'(ifm.overrun), 1);
    chk("ovr_w2_pout", 32'(ifm.pout), 32'hC);
    word_in(4'b1010, 0);
    chk("ovr_w3_msb", 32'(ifm.pout), 32'hC);
    chk("ovr_w3_lsb", 32'(ifl.pout), 32'h3);
    clr_err();
    chk("ovr_clr", 32'(ifm.overrun), 0);
    chk("ovr_clr_valid", 32'(ifm.pout_valid), 1);
    consume();

    // framing error
    bit_in(1, 1);
    chk("ferr_none", 32'(ifm.frame_err), 0);
    bit_in(0, 0);
    bit_in(0, 1);
    chk("ferr_set", 32'(ifm.frame_err), 1);
    bit_in(1, 0); bit_in(1, 0);
    chk("ferr_valid3", 32'(ifm.pout_valid), 0);
    bit_in(0, 0);
    chk("ferr_msb", 32'(ifm.pout), 32'h6);
    chk("ferr_lsb", 32'(ifl.pout), 32'h6);
    clr_err();
    chk("ferr_clr", 32'(ifm.frame_err), 0);
    consume();

    // set beats clear on the same edge
    bit_in(1, 1);
    ifm.err_clr = 1'b1;
    bit_in(0, 1);
    ifm.err_clr = 1'b0;
    chk("ferr_prio", 32'(ifm.frame_err), 1);
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
    chk("prio_msb", 32'(ifm.pout), 32'h5);
    chk("prio_lsb", 32'(ifl.pout), 32'hA);
    clr_err();
    consume();

    // gaps between strobes
    bit_in(1, 1); step(); step(); step();
    bit_in(1, 0); step(); step();
    bit_in(0, 0); step();
    chk("gap_valid3", 32'(ifm.pout_valid), 0);
    bit_in(0, 0);
    chk("gap_msb", 32'(ifm.pout), 32'hC);
    chk("gap_lsb", 32'(ifl.pout), 32'h3);

    // reset mid-word with a pending word
    bit_in(1, 1); bit_in(0, 0); bit_in(1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(ifm.pout_valid), 0);
    chk("mrst_pout", 32'(ifm.pout), 0);
    bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);
    chk("mrst_valid3", 32'(ifm.pout_valid), 0);
    bit_in(0, 0);
    chk("mrst_word", 32'(ifm.pout), 32'h6);
    chk("mrst_done", 32'(ifm.pout_valid), 1);
    chk("mrst_ferr", 32'(ifm.frame_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer. It is the receive end of the team's PISO shift-register serial link.
- Shifts a serial bit stream into a WIDTH-bit word and counts bits to the frame boundary.
- Each completed word moves to a holding register, presented with a valid/ready handshake.
- Detects overrun and framing (short-frame) errors.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in pout[WIDTH-1]; 0 = first bit lands in pout[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
- sin  input  1  serial data bit.
- sin_en  input  1  bit strobe; sin is sampled only when sin_en=1.
- sin_start  input  1  frame start; valid only with sin_en=1; marks sin as bit 0 of a new word.
- pout  output  WIDTH  received word from the holding register.
- pout_valid  output  1  holding register contains an unconsumed word.
- pout_ready  input  1  consumer accepts pout when pout_valid=1 and pout_ready=1.
- overrun  output  1  sticky; a completed word was dropped because the holding register was full.
- frame_err  output  1  sticky; sin_start arrived mid-word, so the partial word was discarded.
- err_clr  input  1  clears overrun and frame_err.

Behaviour:
- Reset (rst=1 at an edge): shift register = 0, bit count = 0, pout = 0, pout_valid = 0, overrun = 0, frame_err = 0. Reset wins over every other input, including mid-word and with a pending word.
- Shift, when sin_en=1:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - cnt increments by 1.
  - With sin_en=0, sreg and cnt hold.
- sin_start=1 with sin_en=1:
  - cnt restarts, and this bit is bit 0 of the new word.
  - If cnt was nonzero before the edge, frame_err <= 1 and the partial word is discarded.
  - sin_start with sin_en=0 is ignored.
- Word completion: occurs on the edge where the WIDTH-th bit is shifted (cnt was WIDTH-1).
  - The completed word (sreg with the new bit included) is the transfer candidate.
  - cnt wraps to 0.
  - Back-to-back words need no sin_start.
- Holding register transfer, evaluated on the completion edge:
  - pout_valid=0: pout <= word, pout_valid <= 1.
  - pout_valid=1 and pout_ready=1 on the same edge: pout <= new word, pout_valid stays 1, no overrun.
  - pout_valid=1 and pout_ready=0: the new word is dropped, pout is unchanged, overrun <= 1.
- Handshake without completion: pout_valid=1 and pout_ready=1 gives pout_valid <= 0; pout holds its last value.
- Latency: pout_valid rises on the same edge that samples the last bit. pout is visible in the cycle after that edge.
- Throughput: one word per WIDTH strobes. The holding register gives one word of slack.
- Error flags:
  - err_clr=1: both flags <= 0.
  - Set takes priority over clear on the same edge.
- Counter width: $clog2(WIDTH). Compare against WIDTH-1 at full counter width, so non-power-of-two WIDTH wraps correctly.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package sipo_pkg holds:
  - default WIDTH constant;
  - function cnt_w(width) returning $clog2(width);
  - localparam encodings for bit order, MSB_FIRST_C=1 and LSB_FIRST_C=0.
- One natural sub-module: sipo_hold_reg.
  - Contains the holding register, pout_valid/pout_ready handshake and overrun logic.
  - Inputs: word, word_done, pout_ready.
  - The top level keeps the shift register, bit counter and framing logic.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then sin_en=0 for 10 cycles -> pout=0, pout_valid=0, overrun=0, frame_err=0 throughout.
- Basic receive, WIDTH=4, MSB_FIRST=1: sin_start on the first bit, stream 1,1,0,0, pout_ready=0 -> pout=4'b1100 with pout_valid=1 after the 4th strobe edge.
  - Then pout_ready=1 for one cycle -> pout_valid=0.
  - Rerun with MSB_FIRST=0 -> pout=4'b0011.
- Back-to-back with simultaneous handshake: stream 1100 then 0110 with sin_en held high, pout_ready=1 on the 8th strobe edge -> pout=4'b0110, pout_valid stays 1, overrun=0.
- Overrun: three words 1100, 0110, 1010 with pout_ready=0 -> pout stays 4'b1100, overrun=1 after word 2.
  - err_clr=1 -> overrun=0.
- Framing error: 2 bits (1,0), then sin_start with stream 0,1,1,0 -> frame_err=1, pout=4'b0110.
- Gaps and reset mid-word: strobes spaced by idle cycles (sin_en=0) -> same word as the contiguous case.
  - rst after 3 bits, then a new 4-bit word -> only the new word is received; count restarted from 0.
